lut_dac_spi_tx: RTL
===================

Name: lut_dac_spi_tx

Overview:
- Downstream stage of the LUT waveform generator. Consumes each LUT_VALUE sample plus its LUT_END tag.
- Serialises each sample into one fixed-format SPI write frame for an external serial DAC (mode 0, MSB first).
- Single-entry holding buffer decouples the generator's sample strobe from the serial transfer.
- Reports per-frame completion and a sticky overrun flag to the controlling logic.

Parameters:
- DATA_WIDTH, 8, sample width; matches generator LUT_VALUE width.
- FRAME_WIDTH, 16, bits per SPI frame; must be >= 4 + DATA_WIDTH.
- CMD_WORD, 4'h3, 4-bit DAC command prefix placed in frame MSBs.
- CLK_DIV, 4, CLK_SYS cycles per SCLK half-period; must be >= 1.
- CS_GAP, 2, minimum CLK_SYS cycles CSN stays high between frames; must be >= 1.

Ports:
- CLK_SYS  in  1  system clock; all logic on rising edge.
- nRST  in  1  synchronous, active-low reset.
- EN  in  1  enable; 0 blocks sample capture and clears the holding buffer.
- DATA_IN  in  DATA_WIDTH  sample from generator (LUT_VALUE).
- DATA_VLD  in  1  one-cycle strobe; DATA_IN and DATA_LAST are valid in that cycle.
- DATA_LAST  in  1  LUT_END of the generator, tagged onto the sample.
- DATA_RDY  out  1  combinational EN & !buf_full.
- BUSY  out  1  1 from frame load until return to IDLE.
- SPI_SCLK  out  1  serial clock; idles low.
- SPI_MOSI  out  1  serial data.
- SPI_CSN  out  1  chip select, active low.
- FRAME_DONE  out  1  one-cycle pulse when CSN returns high.
- FRAME_LAST  out  1  tag of the finished frame; valid while FRAME_DONE=1, otherwise 0.
- OVERRUN  out  1  sticky: a sample was dropped.

Behaviour:
- Reset (nRST=0 at clock edge), takes effect at the next edge, including mid-frame:
  - SPI_CSN=1, SPI_SCLK=0, SPI_MOSI=0, BUSY=0, FRAME_DONE=0, FRAME_LAST=0, OVERRUN=0.
  - Buffer empty, state IDLE, all counters 0.
  - A partial frame is abandoned with no FRAME_DONE.
- Frame format: {CMD_WORD, DATA_IN, (FRAME_WIDTH-4-DATA_WIDTH) zeros}, sent MSB first.
- Holding buffer (one entry: data plus tag):
  - DATA_VLD=1, EN=1, buffer empty: capture.
  - DATA_VLD=1, EN=1, buffer full and not being loaded this cycle: drop the new sample, set OVERRUN; the buffered sample is kept.
  - DATA_VLD in the same cycle the buffer is loaded into the shifter: accepted, no overrun.
  - EN=0: buffer cleared, DATA_VLD ignored, OVERRUN unchanged.
  - OVERRUN clears only on reset.
- FSM states: IDLE, SHIFT, HOLD, GAP.
- IDLE:
  - If buf_full & EN, at the next edge: load shifter, free buffer, CSN=0, SCLK=0, MOSI=frame MSB, BUSY=1, go to SHIFT.
  - Otherwise CSN=1, SCLK=0, BUSY=0.
- SHIFT: each bit lasts 2*CLK_DIV cycles.
  - SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - MOSI changes only at the falling transition, i.e. the start of the next bit.
  - After the high phase of bit FRAME_WIDTH-1 (the last bit), SCLK=0 and go to HOLD.
  - Exactly FRAME_WIDTH rising SCLK edges per frame; first rising edge CLK_DIV cycles after CSN falls.
- HOLD: SCLK=0, CSN=0 for CLK_DIV cycles. Then CSN=1, FRAME_DONE=1 and FRAME_LAST=tag in the same cycle, go to GAP.
- GAP: CS_GAP cycles with CSN=1, then IDLE.
- CSN low duration is exactly FRAME_WIDTH*2*CLK_DIV + CLK_DIV cycles; defaults give 132.
- Back-to-back throughput is 2*CLK_DIV*FRAME_WIDTH + CLK_DIV + CS_GAP + 1 cycles per frame; defaults give 135.
- EN falling mid-frame: the current frame completes normally; no further frames start.
- DATA_IN is sampled only at capture; later changes do not affect a frame in flight.

Test Plan:
- Reset mid-frame: assert nRST=0 during SHIFT -> next edge CSN=1, SCLK=0, MOSI=0, BUSY=0, no FRAME_DONE; the buffered sample is discarded.
- Single sample: EN=1, DATA_IN=8'hA5, DATA_VLD pulse -> MOSI stream 16'h3A50 captured on SCLK rising edges; 16 rising edges; CSN low 132 cycles; first rise 4 cycles after CSN falls; FRAME_DONE coincides with CSN rising.
- Back-to-back: DATA_IN 8'h00 then 8'hFF, each strobed as soon as DATA_RDY=1 -> frames 16'h3000 and 16'h3FF0; CSN-fall to CSN-fall spacing 135 cycles; OVERRUN stays 0.
- Overrun: three strobes 8'h11, 8'h22, 8'h33 on consecutive cycles while idle -> 8'h11 and 8'h22 transmitted, 8'h33 dropped, OVERRUN=1 and still 1 after both frames finish.
- Last tag: drive a full 32-sample generator period at the generator's trigger rate (slower than 135 cycles) -> 32 frames, FRAME_LAST=1 only on FRAME_DONE of the frame carrying LUT_END.
- EN drop: clear EN in mid-SHIFT with the buffer full -> current frame completes with FRAME_DONE; buffer cleared; no second frame; DATA_RDY=0 while EN=0.

Source files
------------

// File: rtl/lut_dac_spi_tx.sv
// lut_dac_spi_tx: buffers LUT samples and shifts each out as one mode-0 SPI DAC write frame.
module lut_dac_spi_tx #(
  parameter int          DATA_WIDTH  = 8,
  parameter int          FRAME_WIDTH = 16,
  parameter logic [3:0]  CMD_WORD    = 4'h3,
  parameter int          CLK_DIV     = 4,
  parameter int          CS_GAP      = 2
) (
  input  logic                  CLK_SYS,
  input  logic                  nRST,
  input  logic                  EN,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  DATA_VLD,
  input  logic                  DATA_LAST,
  output logic                  DATA_RDY,
  output logic                  BUSY,
  output logic                  SPI_SCLK,
  output logic                  SPI_MOSI,
  output logic                  SPI_CSN,
  output logic                  FRAME_DONE,
  output logic                  FRAME_LAST,
  output logic                  OVERRUN
);
  localparam int CW = $clog2(2 * CLK_DIV + CS_GAP + 1);
  localparam int BW = $clog2(FRAME_WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;
  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [BW-1:0]          bit_cnt, bit_cnt_n;
  logic [FRAME_WIDTH-1:0] shreg, shreg_n, frame;
  logic [DATA_WIDTH-1:0]  buf_data;
  logic                   buf_full, buf_last, tag, tag_n, load;
  logic                   sclk_n, mosi_n, csn_n, done_n, last_n;
  assign frame    = FRAME_WIDTH'({CMD_WORD, buf_data}) << (FRAME_WIDTH - 4 - DATA_WIDTH);
  assign load     = state == IDLE && buf_full && EN;
  assign DATA_RDY = EN && !buf_full;
  assign BUSY     = state != IDLE;
  // A strobe in the load cycle refills the slot being emptied, so it is not an overrun.
  always_ff @(posedge CLK_SYS)
    if (!nRST) begin
      buf_full <= 1'b0;
      buf_data <= '0;
      buf_last <= 1'b0;
      OVERRUN  <= 1'b0;
    end else if (!EN)
      buf_full <= 1'b0;
    else if (DATA_VLD && (!buf_full || load)) begin
      buf_full <= 1'b1;
      buf_data <= DATA_IN;
      buf_last <= DATA_LAST;
    end else if (DATA_VLD)
      OVERRUN <= 1'b1;
    else if (load)
      buf_full <= 1'b0;
  always_ff @(posedge CLK_SYS)
    if (!nRST) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      tag        <= 1'b0;
      SPI_SCLK   <= 1'b0;
      SPI_MOSI   <= 1'b0;
      SPI_CSN    <= 1'b1;
      FRAME_DONE <= 1'b0;
      FRAME_LAST <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      tag        <= tag_n;
      SPI_SCLK   <= sclk_n;
      SPI_MOSI   <= mosi_n;
      SPI_CSN    <= csn_n;
      FRAME_DONE <= done_n;
      FRAME_LAST <= last_n;
    end
  // cnt times the bit phases in SHIFT, the CSN hold tail in HOLD and the CSN-high gap in GAP.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    tag_n     = tag;
    sclk_n    = SPI_SCLK;
    mosi_n    = SPI_MOSI;
    csn_n     = SPI_CSN;
    done_n    = 1'b0;
    last_n    = 1'b0;
    case (state)
      IDLE: if (load) begin
        state_n   = SHIFT;
        cnt_n     = '0;
        bit_cnt_n = '0;
        shreg_n   = frame << 1;
        mosi_n    = frame[FRAME_WIDTH-1];
        tag_n     = buf_last;
        csn_n     = 1'b0;
        sclk_n    = 1'b0;
      end
      SHIFT: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(CLK_DIV - 1)) sclk_n = 1'b1;
        if (cnt == CW'(2 * CLK_DIV - 1)) begin
          cnt_n  = '0;
          sclk_n = 1'b0;
          if (bit_cnt == BW'(FRAME_WIDTH - 1)) state_n = HOLD;
          else begin
            bit_cnt_n = bit_cnt + 1'b1;
            mosi_n    = shreg[FRAME_WIDTH-1];
            shreg_n   = shreg << 1;
          end
        end
      end
      HOLD: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(CLK_DIV - 1)) begin
          state_n = GAP;
          cnt_n   = '0;
          csn_n   = 1'b1;
          mosi_n  = 1'b0;
          done_n  = 1'b1;
          last_n  = tag;
        end
      end
      GAP: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(CS_GAP - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
